// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter.
// Contents:
//   arb_state_e  - arbiter FSM state encoding (IDLE / GRANT0 / GRANT1)
//   REQ0, REQ1   - requester index constants, as stored in the last-served register
//   grant_state  - maps a requester index to the state that grants it
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // State that hands the write port to requester idx.
  function automatic arb_state_e grant_state(input logic idx);
    arb_state_e st;
    if (idx == REQ1) st = ST_GRANT1;
    else             st = ST_GRANT0;
    return st;
  endfunction

endpackage

// File: rtl/fifo_arb_beat_cnt.sv
// Accepted-beat statistics counter: CNT_W wide, wraps modulo 2^CNT_W.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, clears the count
//   en    - count one beat this cycle
//   count - current count
module fifo_arb_beat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Free-running wrap on overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Two-requester round-robin arbiter sharing one FIFO write port.
// A requester is granted for a burst of up to MAX_BURST beats; accepted
// beats pass combinationally to the FIFO write port. FIFO full stalls the
// burst in place, almost-full only blocks new grants.
// Optional feature macro: FIFO_WR_ARB_STATS_EN adds per-requester
// accepted-beat counters on o_cnt0 / o_cnt1.
// Ports:
//   i_clk, i_rst                  - clock, synchronous active-high reset
//   i_reqN_dv, i_reqN_data        - requester N beat offer
//   o_reqN_ready                  - requester N beat accepted when high with dv
//   o_wr_dv, o_wr_data            - FIFO write port
//   i_full, i_af_flag             - FIFO full / almost-full flags
//   o_grant                       - one-hot current grant, 00 when idle
//   o_cnt0, o_cnt1                - accepted-beat counts (stats build only)
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_dv,
  input  logic [WIDTH-1:0] i_req0_data,
  output logic             o_req0_ready,
  input  logic             i_req1_dv,
  input  logic [WIDTH-1:0] i_req1_data,
  output logic             o_req1_ready,
  output logic             o_wr_dv,
  output logic [WIDTH-1:0] o_wr_data,
  input  logic             i_full,
  input  logic             i_af_flag,
  output logic [1:0]       o_grant
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] o_cnt0,
  output logic [CNT_W-1:0] o_cnt1
`endif
);

  localparam int unsigned BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

  // Reject configurations outside the supported range at elaboration.
  if (MAX_BURST < 1 || MAX_BURST > 256 || CNT_W < 1 || WIDTH < 1) begin : g_bad_param
    $error("fifo_wr_arbiter: illegal parameter set");
  end

  arb_state_e        state;
  logic              last;
  logic [BEAT_W-1:0] beat;

  logic grant0;
  logic grant1;
  logic xfer0;
  logic xfer1;
  logic cur;
  logic cur_dv;
  logic other_dv;
  logic burst_done;
  logic release_now;
  logic pick0;

  assign grant0 = (state == ST_GRANT0);
  assign grant1 = (state == ST_GRANT1);

  // Ready is also killed by reset so nothing is written in the reset cycle.
  assign o_req0_ready = grant0 & ~i_full & ~i_rst;
  assign o_req1_ready = grant1 & ~i_full & ~i_rst;

  assign xfer0   = i_req0_dv & o_req0_ready;
  assign xfer1   = i_req1_dv & o_req1_ready;
  assign o_wr_dv = xfer0 | xfer1;

  // Data follows the grant, not the transfer; zero when nobody owns the port.
  always_comb begin
    o_wr_data = '0;
    if (grant0) begin
      o_wr_data = i_req0_data;
    end else if (grant1) begin
      o_wr_data = i_req1_data;
    end
  end

  assign o_grant = {grant1, grant0};

  // Current owner and the competing requester, valid while granted.
  assign cur      = grant1 ? REQ1 : REQ0;
  assign cur_dv   = grant1 ? i_req1_dv : i_req0_dv;
  assign other_dv = grant1 ? i_req0_dv : i_req1_dv;

  // Burst ends on its last beat or as soon as the owner stops offering data.
  assign burst_done  = o_wr_dv & (beat == LAST_BEAT);
  assign release_now = burst_done | ~cur_dv;

  // From IDLE: requester 0 wins when alone, or when both ask and 1 went last.
  assign pick0 = i_req0_dv & (~i_req1_dv | (last == REQ1));

  // Arbiter FSM with last-served and beat-counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      last  <= REQ1;
      beat  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!i_af_flag && (i_req0_dv || i_req1_dv)) begin
            state <= pick0 ? ST_GRANT0 : ST_GRANT1;
            beat  <= '0;
          end
        end
        ST_GRANT0, ST_GRANT1: begin
          if (release_now) begin
            last <= cur;
            // Hand straight over to the other side; never back to the owner.
            if (other_dv && !i_af_flag) begin
              state <= grant_state(~cur);
              beat  <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else if (o_wr_dv) begin
            beat <= beat + BEAT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  fifo_arb_beat_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt0 (
    .clk  (i_clk),
    .rst  (i_rst),
    .en   (xfer0),
    .count(o_cnt0)
  );

  fifo_arb_beat_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt1 (
    .clk  (i_clk),
    .rst  (i_rst),
    .en   (xfer1),
    .count(o_cnt1)
  );
`endif

endmodule
